i2s_tx_serializer: RTL and testbench

- Audio output stage fed by the PLL's 50 MHz system clock output; its enable is qualified by the PLL lock output.
- Accepts stereo PCM samples from the WAV decode path over a valid/ready handshake and buffers one sample pair.
- Generates I2S BCLK/LRCK by integer division of clk and serializes MSB-first, Philips I2S alignment (MSB one BCLK after the LRCK edge) to the external DAC.

---
 rtl/i2s_tx_serializer.sv | 193 +++++++++++++++++++
 tb/tb_i2s_tx_serializer.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_serializer.sv
// ---------------------------------------------------------------------------
// i2s_tx_serializer
//
// Purpose:
//   I2S transmit stage. Buffers one stereo PCM pair from the decode path
//   over a valid/ready handshake, divides clk down to BCLK/LRCK and shifts
//   the pair out MSB-first with Philips alignment (MSB one BCLK after the
//   LRCK edge). Every output transition happens on the BCLK falling edge,
//   so the DAC samples on the rising edge. The serializer runs only while
//   the PLL is locked and playback is enabled; otherwise it is held idle
//   with the buffer flushed.
//
// Ports:
//   clk_i           system clock (PLL clkout0)
//   rst_i           synchronous reset, active-high, highest priority
//   pll_lock_i      PLL lock; low forces idle
//   en_i            playback enable
//   s_left_i        left sample, two's complement
//   s_right_i       right sample, two's complement
//   s_valid_i       sample pair valid
//   s_ready_o       buffer can accept a pair
//   i2s_bclk_o      bit clock
//   i2s_lrck_o      word select (0 = left, 1 = right)
//   i2s_sdata_o     serial data
//   running_o       serializer active
//   underrun_o      one-cycle pulse when a frame starts with an empty buffer
//   underrun_cnt_o  saturating underrun count (cleared only by rst_i)
// ---------------------------------------------------------------------------
module i2s_tx_serializer #(
  parameter int DATA_WIDTH    = 16,
  parameter int SLOT_WIDTH    = 32,
  parameter int BCLK_HALF_DIV = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  pll_lock_i,
  input  logic                  en_i,
  input  logic [DATA_WIDTH-1:0] s_left_i,
  input  logic [DATA_WIDTH-1:0] s_right_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  output logic                  i2s_bclk_o,
  output logic                  i2s_lrck_o,
  output logic                  i2s_sdata_o,
  output logic                  running_o,
  output logic                  underrun_o,
  output logic [15:0]           underrun_cnt_o
);

  localparam int FRAME_BITS = 2 * SLOT_WIDTH;
  localparam int PAD_BITS   = SLOT_WIDTH - DATA_WIDTH;
  localparam int DIV_W      = (BCLK_HALF_DIV > 1) ? $clog2(BCLK_HALF_DIV) : 1;
  localparam int POS_W      = $clog2(FRAME_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BCLK_HALF_DIV - 1);
  localparam logic [POS_W-1:0] POS_LAST  = POS_W'(FRAME_BITS - 1);
  localparam logic [POS_W-1:0] POS_RIGHT = POS_W'(SLOT_WIDTH);

  // Left-justify a sample inside its slot; bits below the LSB are zero.
  function automatic logic [SLOT_WIDTH-1:0] pad_slot(input logic [DATA_WIDTH-1:0] x);
    pad_slot = SLOT_WIDTH'(x) << PAD_BITS;
  endfunction

  logic                  active_d, active_q;
  logic [DIV_W-1:0]      div_cnt_d, div_cnt_q;
  logic                  bclk_d, bclk_q;
  logic [POS_W-1:0]      pos_d, pos_q;
  logic                  lrck_d, lrck_q;
  logic [FRAME_BITS-1:0] sreg_d, sreg_q;
  logic [DATA_WIDTH-1:0] buf_l_d, buf_l_q;
  logic [DATA_WIDTH-1:0] buf_r_d, buf_r_q;
  logic                  full_d, full_q;
  logic                  underrun_d, underrun_q;
  logic [15:0]           ucnt_d, ucnt_q;

  logic                  run_ok;
  logic                  div_wrap;
  logic                  fe;
  logic                  load;
  logic                  accept;
  logic [POS_W-1:0]      pos_next;

  assign active_d = pll_lock_i & en_i;

  // Counting needs both the live and the registered enable: the live term
  // makes a lock drop idle everything on the same edge that running falls,
  // the registered term holds the divider at zero for the activation edge so
  // the first falling BCLK lands exactly 2*BCLK_HALF_DIV clocks after
  // running rises.
  assign run_ok   = active_d & active_q;
  assign div_wrap = (div_cnt_q == DIV_LAST);
  assign fe       = run_ok & div_wrap & bclk_q;
  // The falling edge that moves p from 0 to 1 starts a new frame.
  assign load     = fe & (pos_q == '0);
  assign pos_next = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);

  assign s_ready_o = active_q & ~full_q;
  assign accept    = s_valid_i & s_ready_o;

  always_comb begin
    div_cnt_d  = div_cnt_q;
    bclk_d     = bclk_q;
    pos_d      = pos_q;
    lrck_d     = lrck_q;
    sreg_d     = sreg_q;
    buf_l_d    = buf_l_q;
    buf_r_d    = buf_r_q;
    full_d     = full_q;
    underrun_d = 1'b0;
    ucnt_d     = ucnt_q;

    if (!run_ok) begin
      // Idle: everything back to the frame start, buffer flushed,
      // underrun count kept.
      div_cnt_d = '0;
      bclk_d    = 1'b0;
      pos_d     = '0;
      lrck_d    = 1'b0;
      sreg_d    = '0;
      buf_l_d   = '0;
      buf_r_d   = '0;
      full_d    = 1'b0;
    end else begin
      div_cnt_d = div_wrap ? '0 : div_cnt_q + DIV_W'(1);
      if (div_wrap) begin
        bclk_d = ~bclk_q;
      end

      if (fe) begin
        pos_d  = pos_next;
        lrck_d = (pos_next >= POS_RIGHT);
        sreg_d = {sreg_q[FRAME_BITS-2:0], 1'b0};
      end

      if (load) begin
        full_d = 1'b0;
        if (full_q) begin
          sreg_d = {pad_slot(buf_l_q), pad_slot(buf_r_q)};
        end else begin
          sreg_d     = '0;
          underrun_d = 1'b1;
          if (ucnt_q != 16'hFFFF) begin
            ucnt_d = ucnt_q + 16'd1;
          end
        end
      end

      // Applied after the load so that an accept on the load edge (only
      // possible when the buffer was already empty) leaves it full.
      if (accept) begin
        buf_l_d = s_left_i;
        buf_r_d = s_right_i;
        full_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      active_q   <= 1'b0;
      div_cnt_q  <= '0;
      bclk_q     <= 1'b0;
      pos_q      <= '0;
      lrck_q     <= 1'b0;
      sreg_q     <= '0;
      buf_l_q    <= '0;
      buf_r_q    <= '0;
      full_q     <= 1'b0;
      underrun_q <= 1'b0;
      ucnt_q     <= '0;
    end else begin
      active_q   <= active_d;
      div_cnt_q  <= div_cnt_d;
      bclk_q     <= bclk_d;
      pos_q      <= pos_d;
      lrck_q     <= lrck_d;
      sreg_q     <= sreg_d;
      buf_l_q    <= buf_l_d;
      buf_r_q    <= buf_r_d;
      full_q     <= full_d;
      underrun_q <= underrun_d;
      ucnt_q     <= ucnt_d;
    end
  end

  assign running_o      = active_q;
  assign i2s_bclk_o     = bclk_q;
  assign i2s_lrck_o     = lrck_q;
  assign i2s_sdata_o    = sreg_q[FRAME_BITS-1];
  assign underrun_o     = underrun_q;
  assign underrun_cnt_o = ucnt_q;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// ---------------------------------------------------------------------------
// tb_i2s_tx_serializer
//
// Purpose:
//   Self-checking bench for i2s_tx_serializer. A reference model tracks the
//   time since activation and derives bclk/lrck/sdata from plain arithmetic
//   on that time and the frame word; the buffer is a full flag plus a word.
//   Every cycle the DUT outputs are compared against the model, and frame
//   contents are additionally captured bit by bit and compared against
//   constant tables or the log of accepted pairs.
// ---------------------------------------------------------------------------
module tb_i2s_tx_serializer;

  localparam int DW        = 16;
  localparam int SW        = 32;
  localparam int HD        = 8;
  localparam int FB        = 2 * SW;
  localparam int FE_CLK    = 2 * HD;
  localparam int FRAME_CLK = FB * FE_CLK;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic          rst, lock, en, valid;
  logic [DW-1:0] l_in, r_in;
  logic          s_ready, bclk, lrck, sdata, running, underrun;
  logic [15:0]   ucnt;

  i2s_tx_serializer #(
    .DATA_WIDTH   (DW),
    .SLOT_WIDTH   (SW),
    .BCLK_HALF_DIV(HD)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .pll_lock_i    (lock),
    .en_i          (en),
    .s_left_i      (l_in),
    .s_right_i     (r_in),
    .s_valid_i     (valid),
    .s_ready_o     (s_ready),
    .i2s_bclk_o    (bclk),
    .i2s_lrck_o    (lrck),
    .i2s_sdata_o   (sdata),
    .running_o     (running),
    .underrun_o    (underrun),
    .underrun_cnt_o(ucnt)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model state
  bit              m_run   = 1'b0;
  bit              m_full  = 1'b0;
  bit              m_pulse = 1'b0;
  bit              m_ld    = 1'b0;
  bit              m_acc   = 1'b0;
  int              m_t     = 0;
  logic [2*DW-1:0] m_buf   = '0;
  logic [2*DW-1:0] m_cur   = '0;
  logic [15:0]     m_cnt   = '0;
  bit              fe_seen = 1'b0;
  bit              bp_mode = 1'b0;
  logic [2*DW-1:0] acc_q[$];

  typedef struct {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
    logic [FB-1:0] exp;
  } vec_t;
  vec_t tbl[4];

  function automatic logic [FB-1:0] pad_frame(input logic [2*DW-1:0] w);
    logic [SW-1:0] a, b;
    a = SW'(w[2*DW-1:DW]) << (SW - DW);
    b = SW'(w[DW-1:0]) << (SW - DW);
    return {a, b};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s @cyc %0d: wait bound expired", name, cyc);
  endtask

  // One clock: advance the model with the inputs held across the edge,
  // then compare every output 1 time unit after the edge.
  task automatic step();
    logic            pb, sd;
    logic [21:0]     act, exp;
    logic [FB-1:0]   pf;
    int              n, k;
    pb = bclk;
    @(posedge clk);
    cyc++;
    m_ld  = 1'b0;
    m_acc = 1'b0;
    if (rst) begin
      m_run = 0; m_t = 0; m_full = 0; m_buf = '0; m_cur = '0; m_pulse = 0; m_cnt = '0;
    end else if (!(lock && en)) begin
      m_run = 0; m_t = 0; m_full = 0; m_buf = '0; m_cur = '0; m_pulse = 0;
    end else if (!m_run) begin
      m_run = 1; m_t = 0; m_pulse = 0;
    end else begin
      m_t++;
      m_pulse = 0;
      m_ld  = (m_t % FRAME_CLK) == FE_CLK;
      m_acc = valid && !m_full;
      if (m_ld) begin
        if (m_full) m_cur = m_buf;
        else begin
          m_cur   = '0;
          m_pulse = 1;
          if (m_cnt != 16'hFFFF) m_cnt++;
        end
      end
      if (m_acc) begin
        m_buf  = {l_in, r_in};
        m_full = 1;
      end else if (m_ld) begin
        m_full = 0;
      end
    end
    #1;
    fe_seen = pb & ~bclk;
    n  = m_t / FE_CLK;
    sd = 1'b0;
    if (m_run && n > 0) begin
      k  = (n - 1) % FB;
      pf = pad_frame(m_cur);
      sd = pf[FB-1-k];
    end
    exp = {m_run, m_run & (((m_t / HD) % 2) == 1), m_run & ((n % FB) >= SW), sd,
           m_run & ~m_full, m_pulse, m_cnt};
    act = {running, bclk, lrck, sdata, s_ready, underrun, ucnt};
    check("cycle", 64'(act), 64'(exp));
    if (m_acc) begin
      acc_q.push_back({l_in, r_in});
      if (bp_mode) begin
        l_in = l_in + 16'd1;
        r_in = r_in - 16'd3;
      end
    end
  endtask

  task automatic wait_load();
    for (int i = 0; i < 2 * FRAME_CLK; i++) begin
      step();
      if (m_ld) return;
    end
    timeout("wait_load");
  endtask

  task automatic step_fe();
    for (int i = 0; i < 4 * FE_CLK; i++) begin
      step();
      if (m_run && (m_t % FE_CLK) == 0) return;
    end
    timeout("step_fe");
  endtask

  task automatic wait_dut_fe(output int n);
    n = 0;
    for (int i = 0; i < 8 * FE_CLK; i++) begin
      step();
      n++;
      if (fe_seen) return;
    end
    timeout("wait_dut_fe");
  endtask

  task automatic push(input logic [DW-1:0] l, input logic [DW-1:0] r);
    l_in  = l;
    r_in  = r;
    valid = 1'b1;
    for (int i = 0; i < 2 * FRAME_CLK; i++) begin
      step();
      if (m_acc) begin
        valid = 1'b0;
        return;
      end
    end
    valid = 1'b0;
    timeout("push");
  endtask

  // Called right after a load edge with the bit seen at p=1; gathers the
  // rest of the frame up to and including p=0 of the next frame.
  task automatic collect(input logic first, output logic [FB-1:0] got);
    got = '0;
    got[FB-1] = first;
    for (int k = 1; k < FB; k++) begin
      step_fe();
      got[FB-1-k] = sdata;
    end
  endtask

  task automatic measure_window(input int idx);
    int hi_b, hi_l, fes, pulses, ones, badrun, len;
    logic cur;
    bit first;
    hi_b = 0; hi_l = 0; fes = 0; pulses = 0; ones = 0; badrun = 0;
    cur = bclk; len = 1; first = 1;
    for (int i = 0; i < FRAME_CLK; i++) begin
      step();
      hi_b   += int'(bclk);
      hi_l   += int'(lrck);
      fes    += int'(fe_seen);
      pulses += int'(underrun);
      ones   += int'(sdata);
      if (bclk == cur) len++;
      else begin
        if (!first && len != HD) badrun++;
        first = 0;
        cur = bclk;
        len = 1;
      end
    end
    check($sformatf("bclk_high_w%0d", idx), 64'(hi_b), 64'(FRAME_CLK / 2));
    check($sformatf("lrck_high_w%0d", idx), 64'(hi_l), 64'(FRAME_CLK / 2));
    check($sformatf("fe_count_w%0d", idx), 64'(fes), 64'(FB));
    check($sformatf("bclk_runs_w%0d", idx), 64'(badrun), 64'd0);
    check($sformatf("underrun_pulses_w%0d", idx), 64'(pulses), 64'd1);
    check($sformatf("silence_w%0d", idx), 64'(ones), 64'd0);
  endtask

  initial begin
    logic [FB-1:0] got;
    logic          first;
    int            c0, n;

    tbl[0] = '{16'hA5C3, 16'h1234, 64'hA5C3_0000_1234_0000};
    tbl[1] = '{16'hFFFF, 16'h0001, 64'hFFFF_0000_0001_0000};
    tbl[2] = '{16'h0001, 16'hFFFF, 64'h0001_0000_FFFF_0000};
    tbl[3] = '{16'h8000, 16'h7FFE, 64'h8000_0000_7FFE_0000};

    rst = 1'b1; lock = 1'b1; en = 1'b1; valid = 1'b0; l_in = '0; r_in = '0;
    repeat (4) step();
    check("reset_outputs", 64'({s_ready, bclk, lrck, sdata, running, underrun, ucnt}), 64'd0);

    // Basic output and table-driven frames
    rst = 1'b0;
    step();
    c0 = cyc;
    check("running_rise", 64'(running), 64'd1);
    push(tbl[0].l, tbl[0].r);
    wait_dut_fe(n);
    check("first_fe_delay", 64'(cyc - c0), 64'(FE_CLK));
    for (int i = 0; i < 4; i++) begin
      if (i > 0) wait_load();
      first = sdata;
      if (i < 3) push(tbl[i + 1].l, tbl[i + 1].r);
      collect(first, got);
      check($sformatf("frame_tbl%0d", i), 64'(got), 64'(tbl[i].exp));
    end

    // Underrun: three frames without data, also checks BCLK/LRCK ratios
    for (int w = 0; w < 3; w++) measure_window(w);
    check("underrun_cnt_3", 64'(ucnt), 64'd3);
    push(16'h7FFF, 16'h8000);
    wait_load();
    collect(sdata, got);
    check("frame_after_underrun", 64'(got), 64'h7FFF_0000_8000_0000);
    check("underrun_cnt_hold", 64'(ucnt), 64'd3);

    // Backpressure: valid held high with an incrementing pattern
    wait_load();
    acc_q.delete();
    bp_mode = 1'b1;
    l_in = 16'h0100;
    r_in = 16'hF000;
    valid = 1'b1;
    for (int f = 0; f < 10; f++) begin
      wait_load();
      collect(sdata, got);
      if (acc_q.size() > f)
        check($sformatf("bp_frame%0d", f), 64'(got), 64'(pad_frame(acc_q[f])));
      else
        timeout("bp_no_transfer");
    end
    valid = 1'b0;
    bp_mode = 1'b0;
    check("bp_transfer_count", 64'(acc_q.size()), 64'd11);

    // Lock drop at p=20
    for (int i = 0; i < 2 * FRAME_CLK; i++) begin
      step();
      if (m_run && (m_t % FE_CLK) == 0 && ((m_t / FE_CLK) % FB) == 20) break;
    end
    lock = 1'b0;
    step();
    check("lock_drop_outputs", 64'({bclk, lrck, sdata, running, s_ready}), 64'd0);
    check("lock_drop_cnt", 64'(ucnt), 64'd4);
    step();

    // Relock: restart from p=0
    lock = 1'b1;
    step();
    c0 = cyc;
    check("relock_running", 64'(running), 64'd1);
    push(16'h1357, 16'hBEEF);
    wait_dut_fe(n);
    check("relock_first_fe", 64'(cyc - c0), 64'(FE_CLK));
    collect(sdata, got);
    check("relock_frame", 64'(got), 64'h1357_0000_BEEF_0000);

    // Reset with underrun_cnt=5 and a full buffer
    wait_load();
    check("pre_reset_cnt", 64'(ucnt), 64'd5);
    push(16'hDEAD, 16'hCAFE);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrun_reset_outputs", 64'({s_ready, bclk, lrck, sdata, running, underrun, ucnt}), 64'd0);
    step();
    wait_dut_fe(n);
    collect(sdata, got);
    check("discarded_after_reset", 64'(got), 64'd0);
    check("cnt_after_reset", 64'(ucnt), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
